// File: rtl/spw_rx_pkg.sv
// Shared definitions for the SpaceWire receive path: control codes, decoder
// states and the bit positions of the sticky error causes.
package spw_rx_pkg;

   localparam logic [1:0] CTRL_FCT = 2'b00;
   localparam logic [1:0] CTRL_EOP = 2'b01;
   localparam logic [1:0] CTRL_EEP = 2'b10;
   localparam logic [1:0] CTRL_ESC = 2'b11;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_HUNT_ESC,
      ST_RUN,
      ST_RUN_ESC
   } rx_state_e;

   localparam int ERR_PARITY = 0;
   localparam int ERR_ESCAPE = 1;
   localparam int ERR_CREDIT = 2;
   localparam int ERR_DISC   = 3;

   // Contribution of a character's payload to the next character's parity:
   // all eight bits for data, only the two code bits for control characters.
   function automatic logic char_bits_parity(input logic flag, input logic [7:0] data);
      return flag ? ^data[1:0] : ^data;
   endfunction

endpackage

// File: rtl/rx_disconnect_timer.sv
// Disconnect watchdog: armed and reloaded by every character, pulses timeout
// once when DISC_CYCLES clocks pass without a character.
module rx_disconnect_timer #(
   parameter int DISC_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic reload,
   output logic timeout
);

   localparam int CNT_W = (DISC_CYCLES > 2) ? $clog2(DISC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(DISC_CYCLES - 1);

   logic             armed;
   logic [CNT_W-1:0] count;

   // Disarming at zero makes timeout a single pulse per idle period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
         count <= '0;
      end else if (reload) begin
         armed <= 1'b1;
         count <= LOAD;
      end else if (armed) begin
         if (count == '0) armed <= 1'b0;
         else             count <= count - 1'b1;
      end
   end

   assign timeout = armed && (count == '0) && !reload;

endmodule

// File: rtl/rx_char_decoder.sv
// SpaceWire receive character decoder: parity, ESC resolution, N-char delivery,
// FCT credit tracking and disconnect detection. Time codes need RX_TIME_CODE_EN.
module rx_char_decoder
   import spw_rx_pkg::*;
#(
   parameter int FCT_MAX     = 7,
   parameter int FCT_CNT_W   = $clog2(FCT_MAX + 1),
   parameter int DISC_CYCLES = 64
) (
   input  logic                 posedge_clk,
   input  logic                 rx_reset,
   input  logic                 char_valid,
   input  logic                 char_flag,
   input  logic                 char_parity,
   input  logic [7:0]           char_data,
   input  logic                 fct_ack,
   output logic                 got_null,
   output logic                 got_null_seen,
   output logic                 got_fct,
   output logic                 got_nchar,
   output logic [8:0]           nchar_data,
   output logic                 got_time_code,
   output logic [7:0]           time_out,
   output logic [FCT_CNT_W-1:0] fct_credit,
   output logic                 rx_error,
   output logic [3:0]           rx_error_cause
);

   localparam logic [FCT_CNT_W-1:0] CREDIT_MAX = FCT_CNT_W'(FCT_MAX);

   rx_state_e            state, state_next;
   logic                 prev_par;
   logic                 disc_timeout;
   logic [1:0]           code;
   logic                 null_p, fct_inc, nchar_p, tc_p;
   logic [8:0]           nchar_val;
   logic                 par_err, esc_err, cred_err;
   logic [3:0]           new_cause;
   logic                 hold;
   logic [FCT_CNT_W-1:0] credit_next;

   assign code = char_data[1:0];

   rx_disconnect_timer #(.DISC_CYCLES(DISC_CYCLES)) u_disc (
      .clk     (posedge_clk),
      .rst     (rx_reset),
      .reload  (char_valid),
      .timeout (disc_timeout)
   );

   always_comb begin
      state_next  = state;
      null_p      = 1'b0;
      fct_inc     = 1'b0;
      nchar_p     = 1'b0;
      nchar_val   = 9'h000;
      tc_p        = 1'b0;
      par_err     = 1'b0;
      esc_err     = 1'b0;
      credit_next = fct_credit;
      if (char_valid) begin
         if (state == ST_RUN || state == ST_RUN_ESC)
            par_err = (prev_par ^ char_parity ^ char_flag) != 1'b1;
         case (state)
            ST_HUNT: begin
               if (char_flag && code == CTRL_ESC) state_next = ST_HUNT_ESC;
            end
            ST_HUNT_ESC: begin
               if (char_flag && code == CTRL_FCT) begin
                  null_p     = 1'b1;
                  state_next = ST_RUN;
               end else begin
                  state_next = ST_HUNT;
               end
            end
            ST_RUN: begin
               if (!char_flag) begin
                  nchar_p   = 1'b1;
                  nchar_val = {1'b0, char_data};
               end else begin
                  case (code)
                     CTRL_FCT: fct_inc = 1'b1;
                     CTRL_EOP: begin nchar_p = 1'b1; nchar_val = 9'h100; end
                     CTRL_EEP: begin nchar_p = 1'b1; nchar_val = 9'h101; end
                     default:  state_next = ST_RUN_ESC;
                  endcase
               end
            end
            default: begin
               state_next = ST_RUN;
               if (char_flag) begin
                  if (code == CTRL_FCT) null_p  = 1'b1;
                  else                  esc_err = 1'b1;
               end
`ifdef RX_TIME_CODE_EN
               else tc_p = 1'b1;
`endif
            end
         endcase
      end
      cred_err = fct_inc && !fct_ack && (fct_credit == CREDIT_MAX);
      if (fct_inc && !fct_ack && !cred_err)
         credit_next = fct_credit + 1'b1;
      else if (!fct_inc && fct_ack && fct_credit != '0)
         credit_next = fct_credit - 1'b1;
      new_cause = '0;
      new_cause[ERR_PARITY] = par_err;
      new_cause[ERR_ESCAPE] = esc_err;
      new_cause[ERR_CREDIT] = cred_err;
      new_cause[ERR_DISC]   = disc_timeout;
      hold = rx_error || (|new_cause);
   end

   always_ff @(posedge posedge_clk or posedge rx_reset) begin
      if (rx_reset) state <= ST_HUNT;
      else if (!hold) state <= state_next;
   end

   // Once an error latches, only the previous-character parity keeps tracking.
   always_ff @(posedge posedge_clk or posedge rx_reset) begin
      if (rx_reset) begin
         prev_par       <= 1'b0;
         got_null       <= 1'b0;
         got_null_seen  <= 1'b0;
         got_fct        <= 1'b0;
         got_nchar      <= 1'b0;
         nchar_data     <= '0;
         fct_credit     <= '0;
         rx_error       <= 1'b0;
         rx_error_cause <= '0;
      end else begin
         if (char_valid) prev_par <= char_bits_parity(char_flag, char_data);
         got_null  <= 1'b0;
         got_fct   <= 1'b0;
         got_nchar <= 1'b0;
         if (!rx_error) begin
            if (|new_cause) begin
               rx_error       <= 1'b1;
               rx_error_cause <= new_cause;
            end else begin
               fct_credit <= credit_next;
               got_null   <= null_p;
               got_fct    <= fct_inc;
               got_nchar  <= nchar_p;
               if (null_p)  got_null_seen <= 1'b1;
               if (nchar_p) nchar_data    <= nchar_val;
            end
         end
      end
   end

`ifdef RX_TIME_CODE_EN
   always_ff @(posedge posedge_clk or posedge rx_reset) begin
      if (rx_reset) begin
         got_time_code <= 1'b0;
         time_out      <= '0;
      end else begin
         got_time_code <= tc_p && !hold;
         if (tc_p && !hold) time_out <= char_data;
      end
   end
`else
   assign got_time_code = 1'b0;
   assign time_out      = '0;
`endif

endmodule

// File: doc/rx_char_decoder.md
# rx_char_decoder

Parametrised successor to the SpaceWire receive ready/FCT logic. Takes assembled characters from the RX shift stage and:
- checks odd parity across consecutive characters;
- resolves ESC sequences into NULL and time codes;
- delivers N-chars (data, EOP, EEP) to the RX FIFO writer;
- maintains a saturating received-FCT credit counter with credit-error detection;
- runs a disconnect timeout.

It sits between the RX deserialiser and the link-state FSM / RX FIFO.

## Interface
- FCT_MAX, 7: max outstanding received FCTs (7 × 8 = 56 N-chars)
- FCT_CNT_W, $clog2(FCT_MAX+1): credit counter width
- DISC_CYCLES, 64: idle clocks after the last character before disconnect; must be ≥ 2
- posedge_clk  in  1  sole clock, rising edge
- rx_reset  in  1  asynchronous, active-high reset
- char_valid  in  1  one-cycle strobe, character fields valid
- char_flag  in  1  1 = control character, 0 = data
- char_parity  in  1  received parity bit
- char_data  in  8  data byte; control code in [1:0] (FCT=00, EOP=01, EEP=10, ESC=11)
- fct_ack  in  1  link-state/TX consumed one FCT credit
- got_null  out  1  pulse, NULL decoded
- got_null_seen  out  1  sticky, first NULL received
- got_fct  out  1  pulse, FCT decoded (RUN only)
- got_nchar  out  1  pulse, N-char valid
- nchar_data  out  9  bit8 = 1 for EOP/EEP; [7:0] data, or 0x00 EOP / 0x01 EEP
- got_time_code  out  1  pulse, time code decoded
- time_out  out  8  last time-code byte, held
- fct_credit  out  FCT_CNT_W  outstanding received FCTs
- rx_error  out  1  sticky OR of causes
- rx_error_cause  out  4  sticky {disconnect, credit, escape, parity}

## Operation
- Four states:
  - HUNT (reset state): waiting for the first NULL.
  - HUNT_ESC: ESC seen while hunting.
  - RUN: normal decode after the first NULL.
  - RUN_ESC: ESC seen while running.
- HUNT: an ESC goes to HUNT_ESC; every other character is ignored.
- HUNT_ESC:
  - FCT produces a NULL: pulse got_null, set got_null_seen, go to RUN.
  - Any other character returns to HUNT with no error.
- RUN:
  - Data: got_nchar with {0, byte}.
  - EOP: got_nchar with 0x100.
  - EEP: got_nchar with 0x101.
  - FCT: got_fct and a credit increment.
  - ESC: go to RUN_ESC.
- RUN_ESC:
  - FCT produces a NULL pulse.
  - Data produces a time code.
  - ESC, EOP or EEP sets the escape error.
  - Every case returns to RUN.
- Parity is checked in RUN and RUN_ESC only. The XOR of the previous character's data bits (8 for data, 2 for control), char_parity and char_flag must equal 1; otherwise set the parity error.
  - The previous-character bits are registered on every char_valid, including in HUNT, so the first RUN character is checked against the NULL's FCT.
- Credit counter:
  - FCT alone increments.
  - fct_ack alone decrements.
  - FCT and fct_ack in the same cycle: counter unchanged.
  - fct_ack at 0 is ignored.
  - FCT at FCT_MAX without fct_ack sets the credit error; the counter holds.
- Disconnect timer:
  - Armed by the first char_valid after reset; reloads on every char_valid.
  - Sets the disconnect error when DISC_CYCLES clocks elapse with no char_valid.
- First error:
  - Latches its cause bit(s) and rx_error.
  - From then on the block suppresses all pulses and freezes the state and the counter until reset.
  - Multiple causes in one cycle all latch.
- A character whose decode raises an error produces no pulse.

## Timing
- All outputs are registered. Pulses are high for exactly one cycle, the cycle after the char_valid that caused them.
- fct_credit updates the cycle after the FCT or fct_ack.
- A cause bit and rx_error assert together, one cycle after the detecting edge.
- The disconnect error asserts exactly DISC_CYCLES clocks after the last char_valid.
- Back-to-back char_valid on every clock is supported.
- Reset values: every output is 0 and the state is HUNT. Asserting reset mid-operation clears all state asynchronously, including the sticky errors.

## Configuration
- RX_TIME_CODE_EN defined: time codes are decoded as described.
- RX_TIME_CODE_EN undefined:
  - ESC+data in RUN_ESC is discarded with no error and no pulse.
  - got_time_code and time_out are tied to 0 and their registers are removed.

## Structure
- Shared package spw_rx_pkg holds:
  - the control-code constants (CTRL_FCT, CTRL_EOP, CTRL_EEP, CTRL_ESC);
  - the state enum;
  - the error-cause bit indices (ERR_PARITY=0, ERR_ESCAPE=1, ERR_CREDIT=2, ERR_DISC=3).
- One sub-module, rx_disconnect_timer (parameter DISC_CYCLES; arm/reload in, timeout pulse out).

## Test plan
- ESC(parity ok) then FCT -> got_null pulse 1 cycle later, got_null_seen=1. Then data 0xA5 -> got_nchar, nchar_data=0x0A5.
- After NULL, 8 FCTs with no fct_ack (FCT_MAX=7) -> fct_credit reaches 7; the 8th sets rx_error_cause=4'b0100, and later characters give no pulses.
- In RUN, ESC then data 0x3F -> got_time_code, time_out=0x3F. Same stimulus with RX_TIME_CODE_EN undefined -> no pulse, no error.
- After NULL, EOP with flipped parity -> rx_error_cause=4'b0001, no got_nchar. ESC then EEP -> rx_error_cause=4'b0010.
- After one character, idle 64 clocks -> disconnect error on exactly cycle 64. Idle 63 clocks then a character -> no error.
- FCT and fct_ack in the same cycle at credit=3 -> credit stays 3. Assert rx_reset mid-stream -> all outputs 0 immediately, state HUNT.
